mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Shares the processor's single-port unified memory between instruction fetch (IF stage), data access (MEM stage load/store) and an optional program loader.
- Sits between the pipeline stages and the memory array.
- Serialises accesses through a small FSM with a fixed memory latency and a starvation guard for fetch.
- Returns read data and completion strobes to the owning requester.

## Interface
Parameters:
- ADDR_W, 10, word-address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from mem_en cycle to valid mem_rdata (≥1)
- STARVE_MAX, 4, consecutive lost decisions before fetch is promoted (0 = never promote)

Ports:
- clk1  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- halted  in  1  processor halted; masks if_req
- if_req / if_addr  in  1 / ADDR_W  fetch request, word address
- if_gnt / if_rvalid  out  1 / 1  fetch grant pulse, completion pulse
- dm_req / dm_we  in  1 / 1  data request, write enable
- dm_addr / dm_wdata  in  ADDR_W / DATA_W  data address, write data
- dm_gnt / dm_rvalid  out  1 / 1  data grant pulse, completion pulse
- ld_req, ld_we, ld_addr, ld_wdata, ld_gnt, ld_rvalid  (as dm_*)  loader port, present only with LOADER_PORT_EN
- rdata  out  DATA_W  read data, valid with any *_rvalid
- mem_en / mem_we  out  1 / 1  memory strobe, write enable
- mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address, write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- Arbitration decisions are taken only at edges ending IDLE or DONE.
- Priority order, highest first: ld, dm, if.
  - Exception: when starve_cnt == STARVE_MAX (and STARVE_MAX ≠ 0), if wins over dm; ld still wins.
- A request is considered only while its req is high at the decision edge.
  - Requesters hold req, addr, we and wdata stable until gnt.
  - req may drop after gnt.
  - A req dropped before gnt is never serviced.
- halted=1 masks if_req. A masked if_req neither wins nor counts as starved.
- starve_cnt:
  - +1 (saturating) at each decision where unmasked if_req lost.
  - Cleared when if wins, or when unmasked if_req is low at a decision edge.
- On a win:
  - Next cycle: state ACCESS, winner's gnt=1 for one cycle, mem_en=1 for one cycle.
  - mem_addr, mem_we and mem_wdata are registered from the winner and held through ACCESS.
- ACCESS:
  - Latency counter loads MEM_LAT-1 and decrements.
  - At the edge where it is 0: register mem_rdata into rdata and go to DONE.
- DONE (one cycle):
  - Owner's rvalid=1; other rvalids stay 0.
  - Writes also pulse rvalid; rdata is then don't-care but is still updated.
- No winner at a DONE-ending edge → IDLE.
- Reset values: state IDLE, starve_cnt 0; all gnt, rvalid, mem_en, mem_we, busy = 0; mem_addr, mem_wdata, rdata = 0.
- Reset asserted mid-access: the transaction is discarded, no rvalid is issued, and outputs take reset values immediately.

## Timing
- Req seen at edge E0 (IDLE) → gnt and mem_en during cycle E0+1 → rvalid during cycle E0+MEM_LAT+2.
- Back-to-back throughput: one access per MEM_LAT+2 cycles, with a new grant in the cycle after DONE.
- All outputs are registered; there is no combinational path from any req to any gnt.
- Simultaneous ld/dm/if requests: exactly one gnt per decision, always.

## Configuration
- LOADER_PORT_EN defined: ld_* ports exist; ld has top priority, including over a promoted if.
- LOADER_PORT_EN undefined: ld_* ports are absent and arbitration is two-way (dm, if); behaviour is otherwise identical.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, DONE)
  - owner-index constants (OWN_IF, OWN_DM, OWN_LD)
  - default parameter constants
- Sub-module mem_arb_pick: combinational priority picker taking masked requests and the promote flag, returning a one-hot winner.

## Test plan
- Single fetch, MEM_LAT=2, if_addr=5 with mem[5]=32'h2801000a → if_gnt at cycle 1, if_rvalid and rdata=32'h2801000a at cycle 4, busy low at cycle 5.
- dm write to addr 9 with wdata 32'hdead_beef, then an if read of 9 → mem_we=1 with addr 9 at the dm grant; the if read returns 32'hdeadbeef.
- Constant dm_req and if_req, STARVE_MAX=4 → dm wins 4 decisions, if wins the 5th, then starve_cnt=0 and dm wins next.
- halted=1 with if_req held → no if_gnt for 20 cycles and starve_cnt stays 0; after halted=0, if is granted at the next decision.
- rst_n pulled low during ACCESS → no rvalid, busy=0 and mem_en=0 immediately; after release, a pending dm_req is granted normally.
- With LOADER_PORT_EN, ld_req, dm_req and if_req all high, starve_cnt=4 → ld_gnt first, then if, then dm.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: states, owner indices and default parameters shared by the memory port arbiter
`timescale 1ns/1ps
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam int OWN_IF = 0;
  localparam int OWN_DM = 1;
  localparam int OWN_LD = 2;
  localparam int N_OWN = 3;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_MEM_LAT = 2;
  localparam int DEF_STARVE_MAX = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side signals of the arbiter; ld_* exist only with LOADER_PORT_EN
`timescale 1ns/1ps
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
  #(parameter int ADDR_W = DEF_ADDR_W, parameter int DATA_W = DEF_DATA_W) ();
  logic halted;
  logic if_req, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
`ifdef LOADER_PORT_EN
  logic ld_req, ld_we, ld_gnt, ld_rvalid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
`endif
  logic [DATA_W-1:0] rdata;
  logic mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic busy;
  modport slave (
    input halted, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
`ifdef LOADER_PORT_EN
    input ld_req, ld_we, ld_addr, ld_wdata,
    output ld_gnt, ld_rvalid,
`endif
    output if_gnt, if_rvalid, dm_gnt, dm_rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
  modport master (
    output halted, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
`ifdef LOADER_PORT_EN
    output ld_req, ld_we, ld_addr, ld_wdata,
    input ld_gnt, ld_rvalid,
`endif
    input if_gnt, if_rvalid, dm_gnt, dm_rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: one-hot priority pick ld > dm > if, with a promoted if jumping ahead of dm
`timescale 1ns/1ps
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [N_OWN-1:0] req,
  input  logic             promote,
  output logic [N_OWN-1:0] win
);
  assign win[OWN_LD] = req[OWN_LD];
  assign win[OWN_DM] = req[OWN_DM] & ~req[OWN_LD] & ~(promote & req[OWN_IF]);
  assign win[OWN_IF] = req[OWN_IF] & ~req[OWN_LD] & (promote | ~req[OWN_DM]);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch/data/loader accesses to a single-port memory; LOADER_PORT_EN adds the ld port
`timescale 1ns/1ps
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input logic clk1,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = STARVE_MAX > 0 ? $clog2(STARVE_MAX + 1) : 1;
  localparam int LW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  state_t state, nxt_state;
  logic [SW-1:0] starve_cnt, nxt_starve;
  logic [LW-1:0] lat;
  logic [N_OWN-1:0] req, win, gnt, rvalid, owner;
  logic decide, promote, sat, if_live, lat_done;
  logic mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, rdata;
  logic ld_req, ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
`ifdef LOADER_PORT_EN
  assign ld_req = bus.ld_req;
  assign ld_we = bus.ld_we;
  assign ld_addr = bus.ld_addr;
  assign ld_wdata = bus.ld_wdata;
  assign bus.ld_gnt = gnt[OWN_LD];
  assign bus.ld_rvalid = rvalid[OWN_LD];
`else
  logic unused_ld;
  assign ld_req = 1'b0;
  assign ld_we = 1'b0;
  assign ld_addr = '0;
  assign ld_wdata = '0;
  assign unused_ld = ^{gnt[OWN_LD], rvalid[OWN_LD]};
`endif
  mem_arb_pick u_pick (.req(req), .promote(promote), .win(win));
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt_state;
  always_comb nxt_state = decide ? (|win ? ACCESS : IDLE) : (lat_done ? DONE : state);
  always_comb begin
    if_live = bus.if_req & ~bus.halted;
    req = '0;
    req[OWN_IF] = if_live;
    req[OWN_DM] = bus.dm_req;
    req[OWN_LD] = ld_req;
    decide = state == IDLE || state == DONE;
    sat = starve_cnt == SW'(STARVE_MAX);
    promote = STARVE_MAX != 0 && sat;
    // the grant cycle still has a stale counter, so it never ends the access
    lat_done = state == ACCESS && !mem_en && lat == '0;
    nxt_starve = !decide ? starve_cnt : (!if_live || win[OWN_IF]) ? '0 : sat ? starve_cnt : starve_cnt + 1'b1;
  end
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      lat <= '0;
      gnt <= '0;
      rvalid <= '0;
      owner <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rdata <= '0;
    end else begin
      starve_cnt <= nxt_starve;
      gnt <= decide ? win : '0;
      mem_en <= decide & |win;
      rvalid <= lat_done ? owner : '0;
      lat <= mem_en ? LW'(MEM_LAT - 1) : (state == ACCESS && lat != '0) ? lat - 1'b1 : lat;
      if (lat_done) rdata <= bus.mem_rdata;
      if (decide && |win) begin
        owner <= win;
        mem_addr <= win[OWN_LD] ? ld_addr : win[OWN_DM] ? bus.dm_addr : bus.if_addr;
        mem_we <= win[OWN_LD] ? ld_we : win[OWN_DM] & bus.dm_we;
        mem_wdata <= win[OWN_LD] ? ld_wdata : bus.dm_wdata;
      end
    end
  end
  assign bus.if_gnt = gnt[OWN_IF];
  assign bus.dm_gnt = gnt[OWN_DM];
  assign bus.if_rvalid = rvalid[OWN_IF];
  assign bus.dm_rvalid = rvalid[OWN_DM];
  assign bus.rdata = rdata;
  assign bus.mem_en = mem_en;
  assign bus.mem_we = mem_we;
  assign bus.mem_addr = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench with a two-cycle-latency memory model
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mem [0:1023];
  logic [31:0] d0 = '0;
  logic [31:0] d1 = '0;
  mem_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) b ();
  mem_port_arbiter dut (.clk1(clk1), .rst_n(rst_n), .bus(b.slave));
  always #5 clk1 = ~clk1;
  assign b.mem_rdata = d1;
  always @(posedge clk1) begin
    if (b.mem_en) begin
      d0 <= mem[b.mem_addr];
      if (b.mem_we) mem[b.mem_addr] = b.mem_wdata;
    end
    d1 <= d0;
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk1);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[5] = 32'h2801000a;
    b.halted = 1'b0;
    b.if_req = 1'b0;
    b.if_addr = '0;
    b.dm_req = 1'b0;
    b.dm_we = 1'b0;
    b.dm_addr = '0;
    b.dm_wdata = '0;
`ifdef LOADER_PORT_EN
    b.ld_req = 1'b0;
    b.ld_we = 1'b0;
    b.ld_addr = '0;
    b.ld_wdata = '0;
`endif
    tick(2);
    check("rst_busy", b.busy, 0);
    check("rst_gnt", {b.if_gnt, b.dm_gnt}, 0);
    check("rst_rvalid", {b.if_rvalid, b.dm_rvalid}, 0);
    check("rst_mem_en", {b.mem_en, b.mem_we}, 0);
    check("rst_mem_addr", b.mem_addr, 0);
    check("rst_mem_wdata", b.mem_wdata, 0);
    check("rst_rdata", b.rdata, 0);
    check("rst_starve", dut.starve_cnt, 0);
    rst_n = 1'b1;
    tick();
    // single fetch
    b.if_req = 1'b1;
    b.if_addr = 10'd5;
    tick();
    check("f_if_gnt", b.if_gnt, 1);
    check("f_dm_gnt", b.dm_gnt, 0);
    check("f_mem_en", b.mem_en, 1);
    check("f_mem_addr", b.mem_addr, 5);
    check("f_busy", b.busy, 1);
    b.if_req = 1'b0;
    tick();
    check("f_gnt_pulse", b.if_gnt, 0);
    check("f_en_pulse", b.mem_en, 0);
    tick(2);
    check("f_if_rvalid", b.if_rvalid, 1);
    check("f_dm_rvalid", b.dm_rvalid, 0);
    check("f_rdata", b.rdata, 32'h2801000a);
    tick();
    check("f_idle", b.busy, 0);
    check("f_rvalid_pulse", b.if_rvalid, 0);
    // data write then fetch of the same word
    b.dm_req = 1'b1;
    b.dm_we = 1'b1;
    b.dm_addr = 10'd9;
    b.dm_wdata = 32'hdeadbeef;
    tick();
    check("w_dm_gnt", b.dm_gnt, 1);
    check("w_mem_we", b.mem_we, 1);
    check("w_mem_addr", b.mem_addr, 9);
    check("w_mem_wdata", b.mem_wdata, 32'hdeadbeef);
    b.dm_req = 1'b0;
    b.dm_we = 1'b0;
    b.if_req = 1'b1;
    b.if_addr = 10'd9;
    tick(3);
    check("w_dm_rvalid", b.dm_rvalid, 1);
    check("w_if_rvalid0", b.if_rvalid, 0);
    tick();
    check("w_if_gnt", b.if_gnt, 1);
    check("w_rd_we", b.mem_we, 0);
    b.if_req = 1'b0;
    tick(3);
    check("w_if_rvalid", b.if_rvalid, 1);
    check("w_rdata", b.rdata, 32'hdeadbeef);
    tick();
    // starvation promotion with constant dm and if requests
    b.dm_req = 1'b1;
    b.dm_addr = 10'd1;
    b.if_req = 1'b1;
    b.if_addr = 10'd2;
    for (int i = 1; i <= 6; i++) begin
      tick(i == 1 ? 1 : 4);
      check($sformatf("s_dm_gnt%0d", i), b.dm_gnt, (i != 5) ? 1 : 0);
      check($sformatf("s_if_gnt%0d", i), b.if_gnt, (i == 5) ? 1 : 0);
      check($sformatf("s_cnt%0d", i), dut.starve_cnt, (i == 5) ? 0 : (i == 6) ? 1 : i);
    end
    b.dm_req = 1'b0;
    b.if_req = 1'b0;
    tick(4);
    check("s_idle", b.busy, 0);
    check("s_cnt_clr", dut.starve_cnt, 0);
    // halted masks fetch
    b.halted = 1'b1;
    b.if_req = 1'b1;
    b.if_addr = 10'd5;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("h_if_gnt%0d", i), b.if_gnt, 0);
    end
    check("h_cnt", dut.starve_cnt, 0);
    check("h_busy", b.busy, 0);
    b.halted = 1'b0;
    tick();
    check("h_if_gnt", b.if_gnt, 1);
    b.if_req = 1'b0;
    tick(3);
    check("h_rvalid", b.if_rvalid, 1);
    check("h_rdata", b.rdata, 32'h2801000a);
    tick();
    // reset during ACCESS
    b.dm_req = 1'b1;
    b.dm_addr = 10'd5;
    tick();
    check("r_dm_gnt", b.dm_gnt, 1);
    tick();
    check("r_busy_pre", b.busy, 1);
    rst_n = 1'b0;
    #1;
    check("r_busy", b.busy, 0);
    check("r_mem_en", b.mem_en, 0);
    check("r_mem_addr", b.mem_addr, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("r_no_rvalid%0d", i), {b.if_rvalid, b.dm_rvalid}, 0);
    end
    rst_n = 1'b1;
    tick();
    check("r_dm_regnt", b.dm_gnt, 1);
    b.dm_req = 1'b0;
    tick(3);
    check("r_dm_rvalid", b.dm_rvalid, 1);
    check("r_rdata", b.rdata, 32'h2801000a);
    tick();
    check("r_idle", b.busy, 0);
`ifdef LOADER_PORT_EN
    // loader beats a promoted fetch, which then beats dm
    b.dm_req = 1'b1;
    b.dm_addr = 10'd1;
    b.if_req = 1'b1;
    b.if_addr = 10'd2;
    for (int i = 1; i <= 4; i++) begin
      tick(i == 1 ? 1 : 4);
      check($sformatf("l_dm_gnt%0d", i), b.dm_gnt, 1);
    end
    check("l_cnt4", dut.starve_cnt, 4);
    b.ld_req = 1'b1;
    b.ld_addr = 10'd5;
    tick(4);
    check("l_ld_gnt", b.ld_gnt, 1);
    check("l_other_gnt", {b.if_gnt, b.dm_gnt}, 0);
    check("l_cnt_sat", dut.starve_cnt, 4);
    b.ld_req = 1'b0;
    tick(3);
    check("l_ld_rvalid", b.ld_rvalid, 1);
    check("l_rdata", b.rdata, 32'h2801000a);
    tick();
    check("l_if_gnt", b.if_gnt, 1);
    check("l_cnt_clr", dut.starve_cnt, 0);
    b.if_req = 1'b0;
    tick(4);
    check("l_dm_gnt", b.dm_gnt, 1);
    b.dm_req = 1'b0;
    tick(4);
    check("l_idle", b.busy, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
